// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the parametrised LFSR generator.
package lfsr_pkg;

    // Feedback structure selected by the mode input.
    localparam logic MODE_FIB = 1'b0;
    localparam logic MODE_GAL = 1'b1;

    // Reference tap masks for the common widths.
    localparam logic [7:0]  FIB_TAPS_8  = 8'hB8;
    localparam logic [31:0] FIB_TAPS_32 = 32'h80200003;
    localparam logic [7:0]  GAL_POLY_8  = 8'h1D;
    localparam logic [31:0] GAL_POLY_32 = 32'h00400007;

    // What the state register does on a given cycle.
    typedef enum logic [1:0] {
        ACT_HOLD    = 2'd0,
        ACT_SEED    = 2'd1,
        ACT_RECOVER = 2'd2,
        ACT_STEP    = 2'd3
    } lfsr_act_e;

    // Even/odd parity of a vector; narrower operands are zero-extended.
    function automatic logic parity64(input logic [63:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state function for Fibonacci or Galois LFSR.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] poly,
    input  logic             mode,
    output logic [WIDTH-1:0] next
);

    logic fb_s;

    // Shift left; Fibonacci inserts tap parity, Galois folds the MSB back through the mask.
    always_comb begin
        fb_s = parity64(64'(Q & poly));
        next = {WIDTH{1'b0}};
        case (mode)
            MODE_FIB: next = {Q[WIDTH-2:0], fb_s};
            MODE_GAL: begin
                if (Q[WIDTH-1]) begin
                    next = {Q[WIDTH-2:0], 1'b0} ^ poly;
                end else begin
                    next = {Q[WIDTH-2:0], 1'b0};
                end
            end
            default: next = {Q[WIDTH-2:0], fb_s};
        endcase
    end

endmodule

// File: rtl/lfsr_gen_param.sv
// Parametrised pseudo-random generator with run-time taps, seed loading,
// all-zero lock-up recovery and period measurement.
module lfsr_gen_param
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] DEFAULT_POLY = WIDTH'(32'h80200003),
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(32'h00000001)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic             mode,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             poly_load,
    input  logic [WIDTH-1:0] poly,
    output logic [WIDTH-1:0] Q,
    output logic             lockup,
    output logic             period_done,
    output logic [WIDTH-1:0] period_len
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] poly_r;
    logic [WIDTH-1:0] seed_r;
    logic [WIDTH-1:0] step_cnt_r;
    logic [WIDTH-1:0] period_len_r;
    logic             lockup_r;
    logic             period_done_r;

    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] cnt_inc_s;
    lfsr_act_e        act_s;

    logic [WIDTH-1:0] q_d_s;
    logic [WIDTH-1:0] poly_d_s;
    logic [WIDTH-1:0] seed_d_s;
    logic [WIDTH-1:0] cnt_d_s;
    logic [WIDTH-1:0] plen_d_s;
    logic             lockup_d_s;
    logic             period_done_d_s;

    // The step always uses the tap mask held before any poly_load this cycle.
    lfsr_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .Q    (q_r),
        .poly (poly_r),
        .mode (mode),
        .next (next_s)
    );

    // Per-cycle action: seed load beats lock-up recovery beats a normal step.
    always_comb begin
        act_s = ACT_HOLD;
        if (seed_load) begin
            act_s = ACT_SEED;
        end else if (en && (q_r == ZERO_W)) begin
            act_s = ACT_RECOVER;
        end else if (en) begin
            act_s = ACT_STEP;
        end else begin
            act_s = ACT_HOLD;
        end
    end

    // Saturating step counter increment.
    always_comb begin
        if (step_cnt_r == ONES_W) begin
            cnt_inc_s = ONES_W;
        end else begin
            cnt_inc_s = step_cnt_r + ONE_W;
        end
    end

    // Next values of all architectural registers.
    always_comb begin
        q_d_s           = q_r;
        seed_d_s        = seed_r;
        cnt_d_s         = step_cnt_r;
        plen_d_s        = period_len_r;
        lockup_d_s      = 1'b0;
        period_done_d_s = 1'b0;

        if (poly_load) begin
            poly_d_s = poly;
        end else begin
            poly_d_s = poly_r;
        end

        case (act_s)
            ACT_SEED: begin
                cnt_d_s = ZERO_W;
                if (seed == ZERO_W) begin
                    q_d_s      = DEFAULT_SEED;
                    seed_d_s   = DEFAULT_SEED;
                    lockup_d_s = 1'b1;
                end else begin
                    q_d_s    = seed;
                    seed_d_s = seed;
                end
            end
            ACT_RECOVER: begin
                q_d_s      = DEFAULT_SEED;
                cnt_d_s    = ZERO_W;
                lockup_d_s = 1'b1;
            end
            ACT_STEP: begin
                q_d_s = next_s;
                if (next_s == seed_r) begin
                    period_done_d_s = 1'b1;
                    plen_d_s        = cnt_inc_s;
                    cnt_d_s         = ZERO_W;
                end else begin
                    cnt_d_s = cnt_inc_s;
                end
            end
            ACT_HOLD: begin
                q_d_s = q_r;
            end
            default: begin
                q_d_s = q_r;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            q_r           <= DEFAULT_SEED;
            seed_r        <= DEFAULT_SEED;
            poly_r        <= DEFAULT_POLY;
            step_cnt_r    <= ZERO_W;
            period_len_r  <= ZERO_W;
            lockup_r      <= 1'b0;
            period_done_r <= 1'b0;
        end else begin
            q_r           <= q_d_s;
            seed_r        <= seed_d_s;
            poly_r        <= poly_d_s;
            step_cnt_r    <= cnt_d_s;
            period_len_r  <= plen_d_s;
            lockup_r      <= lockup_d_s;
            period_done_r <= period_done_d_s;
        end
    end

    assign Q           = q_r;
    assign lockup      = lockup_r;
    assign period_done = period_done_r;
    assign period_len  = period_len_r;

endmodule

// File: tb/tb_lfsr_gen_param.sv
// Scoreboard bench for lfsr_gen_param: a 32-bit default instance and an
// 8-bit instance, each driven against a polynomial-arithmetic reference model.
module tb_lfsr_gen_param;

    typedef struct {
        logic [63:0] q;
        logic        lk;
        logic        pd;
        logic [63:0] plen;
    } exp_t;

    logic        sys_clk;

    logic        rst_a, en_a, mode_a, sl_a, pl_a, lk_a, pd_a;
    logic [31:0] seed_a, poly_a, q_a, plen_a;
    logic        rst_b, en_b, mode_b, sl_b, pl_b, lk_b, pd_b;
    logic [7:0]  seed_b, poly_b, q_b, plen_b;

    exp_t exp_a[$];
    exp_t exp_b[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state, index 0 = 32-bit instance, 1 = 8-bit instance.
    logic [63:0] m_q[2], m_seed[2], m_poly[2], m_cnt[2], m_plen[2];
    logic [63:0] m_mask[2], m_dseed[2], m_dpoly[2];
    int          m_w[2];

    lfsr_gen_param dut_a (
        .sys_clk(sys_clk), .sys_rst(rst_a), .en(en_a), .mode(mode_a),
        .seed_load(sl_a), .seed(seed_a), .poly_load(pl_a), .poly(poly_a),
        .Q(q_a), .lockup(lk_a), .period_done(pd_a), .period_len(plen_a)
    );

    lfsr_gen_param #(
        .WIDTH(8), .DEFAULT_POLY(8'hB8), .DEFAULT_SEED(8'h01)
    ) dut_b (
        .sys_clk(sys_clk), .sys_rst(rst_b), .en(en_b), .mode(mode_b),
        .seed_load(sl_b), .seed(seed_b), .poly_load(pl_b), .poly(poly_b),
        .Q(q_b), .lockup(lk_b), .period_done(pd_b), .period_len(plen_b)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Multiply state by x over GF(2) modulo the mask (Galois), or shift in tap parity (Fibonacci).
    function automatic logic [63:0] ref_next(input logic [63:0] q, input logic [63:0] p,
                                             input logic [63:0] mask, input int w, input logic m);
        logic [63:0] sh;
        sh = (q << 1) & mask;
        if (m) return q[w-1] ? (sh ^ p) : sh;
        return sh | 64'($countones(q & p) % 2);
    endfunction

    // Apply one cycle of rules to the model and queue the expected outputs.
    task automatic model(input int d, input logic rst, input logic en, input logic m,
                         input logic sl, input logic [63:0] sd, input logic pl, input logic [63:0] pp);
        exp_t e;
        logic [63:0] nx;
        e.lk = 1'b0;
        e.pd = 1'b0;
        if (rst) begin
            m_q[d] = m_dseed[d]; m_seed[d] = m_dseed[d]; m_poly[d] = m_dpoly[d];
            m_cnt[d] = 64'd0; m_plen[d] = 64'd0;
        end else begin
            if (sl) begin
                m_cnt[d] = 64'd0;
                if ((sd & m_mask[d]) == 64'd0) begin
                    m_q[d] = m_dseed[d]; m_seed[d] = m_dseed[d]; e.lk = 1'b1;
                end else begin
                    m_q[d] = sd & m_mask[d]; m_seed[d] = sd & m_mask[d];
                end
            end else if (en && m_q[d] == 64'd0) begin
                m_q[d] = m_dseed[d]; m_cnt[d] = 64'd0; e.lk = 1'b1;
            end else if (en) begin
                nx = ref_next(m_q[d], m_poly[d], m_mask[d], m_w[d], m);
                m_q[d] = nx;
                m_cnt[d] = (m_cnt[d] == m_mask[d]) ? m_mask[d] : m_cnt[d] + 64'd1;
                if (nx == m_seed[d]) begin
                    e.pd = 1'b1; m_plen[d] = m_cnt[d]; m_cnt[d] = 64'd0;
                end
            end
            if (pl) m_poly[d] = pp & m_mask[d];
        end
        e.q = m_q[d];
        e.plen = m_plen[d];
        if (d == 0) exp_a.push_back(e);
        else        exp_b.push_back(e);
    endtask

    task automatic drive(input int d, input logic rst, input logic en, input logic m,
                         input logic sl, input logic [63:0] sd, input logic pl, input logic [63:0] pp);
        if (d == 0) begin
            rst_a = rst; en_a = en; mode_a = m; sl_a = sl; seed_a = sd[31:0]; pl_a = pl; poly_a = pp[31:0];
        end else begin
            rst_b = rst; en_b = en; mode_b = m; sl_b = sl; seed_b = sd[7:0]; pl_b = pl; poly_b = pp[7:0];
        end
        model(d, rst, en, m, sl, sd, pl, pp);
    endtask

    // One cycle on instance d while the other instance holds.
    task automatic cyc(input int d, input logic rst, input logic en, input logic m,
                       input logic sl, input logic [63:0] sd, input logic pl, input logic [63:0] pp);
        @(negedge sys_clk);
        drive(d, rst, en, m, sl, sd, pl, pp);
        drive(1 - d, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    endtask

    // Monitor: compare each instance's registered outputs against its queued expectation.
    always @(posedge sys_clk) begin
        exp_t e;
        #1;
        if (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            n_tests++;
            if ({32'd0, q_a} !== e.q || lk_a !== e.lk || pd_a !== e.pd || {32'd0, plen_a} !== e.plen) begin
                n_fail++;
                $display("FAIL w32 t=%0t: got Q=%h lockup=%b period_done=%b period_len=%h, want Q=%h lockup=%b period_done=%b period_len=%h",
                         $time, q_a, lk_a, pd_a, plen_a, e.q[31:0], e.lk, e.pd, e.plen[31:0]);
            end
        end
        if (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            n_tests++;
            if ({56'd0, q_b} !== e.q || lk_b !== e.lk || pd_b !== e.pd || {56'd0, plen_b} !== e.plen) begin
                n_fail++;
                $display("FAIL w8 t=%0t: got Q=%h lockup=%b period_done=%b period_len=%h, want Q=%h lockup=%b period_done=%b period_len=%h",
                         $time, q_b, lk_b, pd_b, plen_b, e.q[7:0], e.lk, e.pd, e.plen[7:0]);
            end
        end
    end

    initial begin
        int d;
        logic [63:0] sd, pp;
        logic sl, pl;

        m_w[0] = 32; m_mask[0] = 64'hFFFF_FFFF; m_dseed[0] = 64'd1; m_dpoly[0] = 64'h8020_0003;
        m_w[1] = 8;  m_mask[1] = 64'hFF;        m_dseed[1] = 64'd1; m_dpoly[1] = 64'hB8;

        rst_a = 1'b1; en_a = 1'b0; mode_a = 1'b0; sl_a = 1'b0; pl_a = 1'b0; seed_a = 32'd0; poly_a = 32'd0;
        rst_b = 1'b1; en_b = 1'b0; mode_b = 1'b0; sl_b = 1'b0; pl_b = 1'b0; seed_b = 8'd0; poly_b = 8'd0;

        // Reset both instances for two cycles.
        repeat (2) begin
            @(negedge sys_clk);
            drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
            drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        end

        // 32-bit defaults: three shifts from seed 1 (Galois, MSB clear).
        repeat (3) cyc(0, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0);

        // 8-bit Fibonacci 0xB8 full period.
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h01, 1'b1, 64'hB8);
        repeat (258) cyc(1, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);

        // 8-bit Galois 0x1D full period.
        cyc(1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h01, 1'b1, 64'h1D);
        repeat (258) cyc(1, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0);

        // Zero seed is replaced by the default, on both widths.
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h00, 1'b0, 64'd0);
        cyc(0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h00, 1'b0, 64'd0);
        cyc(1, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);

        // Zero taps in Fibonacci drain to zero, then recover.
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h01, 1'b1, 64'h00);
        repeat (12) cyc(1, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);

        // Seed load wins over en; then hold for 5 cycles; then reset with pending load and step.
        cyc(1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h5A, 1'b1, 64'hB8);
        repeat (4) cyc(1, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        cyc(1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h33, 1'b0, 64'd0);
        repeat (5) cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        repeat (3) cyc(1, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        cyc(1, 1'b1, 1'b1, 1'b1, 1'b1, 64'h77, 1'b1, 64'h1D);
        repeat (3) cyc(0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        cyc(0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h1234, 1'b0, 64'd0);

        // Randomised traffic on both instances.
        for (int i = 0; i < 1500; i++) begin
            d  = int'($urandom_range(1, 0));
            sl = ($urandom_range(15, 0) == 0);
            pl = ($urandom_range(31, 0) == 0);
            case ($urandom_range(3, 0))
                0:       sd = 64'd0;
                1:       sd = 64'd1;
                default: sd = {$urandom, $urandom};
            endcase
            case ($urandom_range(4, 0))
                0:       pp = 64'd0;
                1:       pp = (d == 0) ? 64'h8020_0003 : 64'hB8;
                2:       pp = (d == 0) ? 64'h0040_0007 : 64'h1D;
                default: pp = {$urandom, $urandom};
            endcase
            cyc(d, ($urandom_range(63, 0) == 0), ($urandom_range(4, 0) != 0),
                1'($urandom_range(1, 0)), sl, sd, pl, pp);
        end

        repeat (3) cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
